alu_rsp_deserializer: RTL and testbench

//  Downstream stage of the serial ALU (vdic_dut_2022). Samples the DUT's dout/dout_valid bit stream.

---
 rtl/vdic_alu_pkg.sv | 38 +++
 rtl/alu_frame_check.sv | 18 +
 rtl/alu_rsp_deserializer.sv | 153 +++++++++++++++
 tb/tb_alu_rsp_deserializer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdic_alu_pkg.sv
// Shared types and constants for the serial ALU response path.
// Frame and response geometry plus the status/operation encodings.
package vdic_alu_pkg;

   localparam int FRAME_W  = 10;
   localparam int N_FRAMES = 3;
   localparam int RSP_W    = FRAME_W * N_FRAMES;
   localparam int CNT_W    = 5;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RSP_W - 1);

   typedef enum logic [7:0] {
      S_NO_ERROR             = 8'h00,
      S_MISSING_DATA         = 8'h01,
      S_DATA_STACK_OVERFLOW  = 8'h02,
      S_OUTPUT_FIFO_OVERFLOW = 8'h04,
      S_DATA_PARITY_ERROR    = 8'h20,
      S_COMMAND_PARITY_ERROR = 8'h40,
      S_INVALID_COMMAND      = 8'h80
   } status_t;

   typedef enum logic [7:0] {
      OP_NOP = 8'h00,
      OP_AND = 8'h01,
      OP_OR  = 8'h02,
      OP_XOR = 8'h03,
      OP_ADD = 8'h10,
      OP_SUB = 8'h20,
      OP_RST = 8'hFF
   } operation_t;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE
   } fsm_state_t;

endpackage

// File: rtl/alu_frame_check.sv
// Splits one 10-bit frame {start, payload[7:0], parity}
// into payload, start bit and parity-error flag.
module alu_frame_check
   import vdic_alu_pkg::*;
#(
   parameter bit PAR_ODD = 1'b0
) (
   input  logic [FRAME_W-1:0] frame_i,
   output logic [7:0]         payload_o,
   output logic               start_o,
   output logic               par_err_o
);

   assign start_o   = frame_i[FRAME_W-1];
   assign payload_o = frame_i[FRAME_W-2:1];
   assign par_err_o = (^frame_i) ^ PAR_ODD;

endmodule

// File: rtl/alu_rsp_deserializer.sv
// Collects the ALU dout bit stream into 3-frame responses and presents
// each one as a single valid/ready beat with error and sticky flags.
module alu_rsp_deserializer
   import vdic_alu_pkg::*;
#(
   parameter bit PAR_ODD = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ser_in,
   input  logic        ser_valid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_status,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_par_err,
   output logic        rsp_start_err,
   output logic        busy,
   output logic        ovf_sticky,
   output logic        trunc_sticky
);

   fsm_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RSP_W-1:0] sr_q, sr_d;
   logic             trunc_q, trunc_d;
   logic             ovf_q, ovf_d;
   logic             vld_q, vld_d;
   logic [7:0]       st_q, st_d;
   logic [15:0]      res_q, res_d;
   logic [2:0]       pe_q, pe_d;
   logic             se_q, se_d;
   logic             load;
   logic             accept;

   logic [7:0]          pl [N_FRAMES];
   logic [N_FRAMES-1:0] sb;
   logic [N_FRAMES-1:0] pe;

   // Stream bit 0 ends up in sr_q[MSB], so frame 0 is the top slice.
   for (genvar f = 0; f < N_FRAMES; f++) begin : g_frm
      alu_frame_check #(
         .PAR_ODD(PAR_ODD)
      ) u_chk (
         .frame_i  (sr_q[RSP_W-1-FRAME_W*f -: FRAME_W]),
         .payload_o(pl[f]),
         .start_o  (sb[f]),
         .par_err_o(pe[f])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      trunc_d = trunc_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ser_valid) begin
               sr_d    = {{(RSP_W-1){1'b0}}, ser_in};
               cnt_d   = CNT_W'(1);
               state_d = RECV;
            end
         end
         RECV: begin
            if (ser_valid) begin
               sr_d  = {sr_q[RSP_W-2:0], ser_in};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  state_d = DONE;
               end
            end else begin
               trunc_d = 1'b1;
               cnt_d   = '0;
               sr_d    = '0;
               state_d = IDLE;
            end
         end
         DONE: begin
            load = 1'b1;
            if (ser_valid) begin
               sr_d    = {{(RSP_W-1){1'b0}}, ser_in};
               cnt_d   = CNT_W'(1);
               state_d = RECV;
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = vld_q & rsp_ready;

   // A load into a full, unaccepted register is dropped.
   always_comb begin
      vld_d = vld_q & ~accept;
      st_d  = st_q;
      res_d = res_q;
      pe_d  = pe_q;
      se_d  = se_q;
      ovf_d = ovf_q;
      if (load) begin
         if (!vld_q || accept) begin
            vld_d = 1'b1;
            st_d  = pl[0];
            res_d = {pl[1], pl[2]};
            pe_d  = pe;
            se_d  = (sb != N_FRAMES'(1));
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         trunc_q <= 1'b0;
         ovf_q   <= 1'b0;
         vld_q   <= 1'b0;
         st_q    <= '0;
         res_q   <= '0;
         pe_q    <= '0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         trunc_q <= trunc_d;
         ovf_q   <= ovf_d;
         vld_q   <= vld_d;
         st_q    <= st_d;
         res_q   <= res_d;
         pe_q    <= pe_d;
         se_q    <= se_d;
      end
   end

   assign rsp_valid     = vld_q;
   assign rsp_status    = st_q;
   assign rsp_result    = res_q;
   assign rsp_par_err   = pe_q;
   assign rsp_start_err = se_q;
   assign busy          = (state_q != IDLE);
   assign ovf_sticky    = ovf_q;
   assign trunc_sticky  = trunc_q;

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
// Self-checking bench for alu_rsp_deserializer: frames are built from
// payloads with plain arithmetic and results compared per scenario.
module tb_alu_rsp_deserializer;

   localparam bit PAR_ODD = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ser_in = 1'b0;
   logic        ser_valid = 1'b0;
   logic        rsp_ready = 1'b0;
   logic        rsp_valid;
   logic [7:0]  rsp_status;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_par_err;
   logic        rsp_start_err;
   logic        busy;
   logic        ovf_sticky;
   logic        trunc_sticky;

   int checks = 0;
   int errors = 0;

   logic        exp_ovf = 1'b0;
   logic        exp_trunc = 1'b0;
   logic [7:0]  last_st = '0;
   logic [15:0] last_res = '0;
   logic [2:0]  last_pe = '0;
   logic        last_se = 1'b0;

   alu_rsp_deserializer #(
      .PAR_ODD(PAR_ODD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ser_in       (ser_in),
      .ser_valid    (ser_valid),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_status   (rsp_status),
      .rsp_result   (rsp_result),
      .rsp_par_err  (rsp_par_err),
      .rsp_start_err(rsp_start_err),
      .busy         (busy),
      .ovf_sticky   (ovf_sticky),
      .trunc_sticky (trunc_sticky)
   );

   always #5 clk = ~clk;

   // Frame = {start, payload MSB first, parity}; flip=1 breaks parity.
   function automatic logic [9:0] mk_frame(input logic s,
                                          input logic [7:0] p,
                                          input logic flip);
      logic par;
      par = (^{s, p}) ^ PAR_ODD ^ flip;
      return {s, p, par};
   endfunction

   // Stream bit k is element [29-k]; bit f of fl/sa belongs to frame f.
   function automatic logic [29:0] mk_rsp(input logic [7:0] st,
                                         input logic [15:0] res,
                                         input logic [2:0] fl,
                                         input logic [2:0] sa);
      return {mk_frame(sa[0], st, fl[0]),
              mk_frame(sa[1], res[15:8], fl[1]),
              mk_frame(sa[2], res[7:0], fl[2])};
   endfunction

   function automatic logic [31:0] obs();
      return {rsp_valid, rsp_status, rsp_result, rsp_par_err,
              rsp_start_err, ovf_sticky, trunc_sticky, busy};
   endfunction

   function automatic logic [31:0] ev(input logic v,
                                     input logic [7:0] st,
                                     input logic [15:0] r,
                                     input logic [2:0] pe,
                                     input logic se,
                                     input logic b);
      return {v, st, r, pe, se, exp_ovf, exp_trunc, b};
   endfunction

   task automatic drive(input logic [29:0] s, input int n,
                        input logic hold);
      for (int k = 0; k < n; k++) begin
         ser_valid = 1'b1;
         ser_in    = s[29-k];
         @(posedge clk);
         #1;
      end
      if (!hold) begin
         ser_valid = 1'b0;
         ser_in    = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [31:0] e;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      e = '0;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", obs(), e);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_decode(input string name,
                              input logic [7:0] st,
                              input logic [15:0] res,
                              input logic [2:0] fl,
                              input logic [2:0] sa);
      logic [31:0] e;
      drive(mk_rsp(st, res, fl, sa), 30, 1'b0);
      e = ev(1'b0, last_st, last_res, last_pe, last_se, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL %s_early: got %h expected %h", name, obs(), e);
      end
      @(posedge clk);
      #1;
      last_st  = st;
      last_res = res;
      last_pe  = fl;
      last_se  = (sa != 3'b001);
      e = ev(1'b1, last_st, last_res, last_pe, last_se, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL %s_load: got %h expected %h", name, obs(), e);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      e = ev(1'b0, last_st, last_res, last_pe, last_se, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL %s_accept: got %h expected %h", name, obs(), e);
      end
   endtask

   task automatic test_random();
      logic [7:0]  st;
      logic [15:0] res;
      logic [2:0]  fl;
      logic [2:0]  sa;
      for (int i = 0; i < 10; i++) begin
         st  = 8'($urandom);
         res = 16'($urandom);
         fl  = 3'($urandom_range(0, 7));
         sa  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         test_decode("random", st, res, fl, sa);
      end
   endtask

   task automatic test_trunc();
      logic [31:0] e;
      drive(mk_rsp(8'h5A, 16'hA5C3, 3'b000, 3'b001), 17, 1'b0);
      e = ev(1'b0, last_st, last_res, last_pe, last_se, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL trunc_busy: got %h expected %h", obs(), e);
      end
      @(posedge clk);
      #1;
      exp_trunc = 1'b1;
      e = ev(1'b0, last_st, last_res, last_pe, last_se, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL trunc_flag: got %h expected %h", obs(), e);
      end
      test_decode("trunc_recover", 8'h00, 16'h01FE, 3'b000, 3'b001);
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      logic [29:0] a;
      logic [29:0] b;
      a = mk_rsp(8'h00, 16'h01FE, 3'b000, 3'b001);
      b = mk_rsp(8'h00, 16'h0003, 3'b000, 3'b001);
      drive(a, 30, 1'b1);
      drive(b, 30, 1'b0);
      e = ev(1'b1, 8'h00, 16'h01FE, 3'b000, 1'b0, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", obs(), e);
      end
      @(posedge clk);
      #1;
      exp_ovf = 1'b1;
      e = ev(1'b1, 8'h00, 16'h01FE, 3'b000, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL b2b_overflow: got %h expected %h", obs(), e);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      drive(a, 30, 1'b1);
      drive(b, 30, 1'b0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      last_st  = 8'h00;
      last_res = 16'h0003;
      last_pe  = 3'b000;
      last_se  = 1'b0;
      e = ev(1'b1, last_st, last_res, last_pe, last_se, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL b2b_replace: got %h expected %h", obs(), e);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      e = ev(1'b0, last_st, last_res, last_pe, last_se, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL b2b_drain: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      drive(mk_rsp(8'h00, 16'h01FE, 3'b000, 3'b001), 12, 1'b1);
      e = ev(1'b0, last_st, last_res, last_pe, last_se, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mid_before: got %h expected %h", obs(), e);
      end
      #2;
      rst       = 1'b1;
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      #1;
      e = '0;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mid_async: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_ovf   = 1'b0;
      exp_trunc = 1'b0;
      last_st   = '0;
      last_res  = '0;
      last_pe   = '0;
      last_se   = 1'b0;
      @(posedge clk);
      #1;
      test_decode("post_reset", 8'h00, 16'h01FE, 3'b000, 3'b001);
   endtask

   initial begin
      test_reset();
      test_decode("basic", 8'h00, 16'h01FE, 3'b000, 3'b001);
      test_decode("invalid_cmd", 8'h80, 16'h0000, 3'b000, 3'b001);
      test_decode("parity", 8'h00, 16'h01FE, 3'b100, 3'b001);
      test_decode("start_bits", 8'h12, 16'h3456, 3'b000, 3'b011);
      test_random();
      test_trunc();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
